ysyx_25030077_idu_seq: RTL

- Decode-stage sequencer sitting between the IFU and the EXU.
- Accepts one instruction per valid/ready handshake and classifies its opcode.
- Emits one or two micro-ops to the EXU, each carrying the 3-bit immediate-type select that drives the immediate generator.
- Handles multi-uop instructions (JAL/JALR), illegal-opcode flagging, back-pressure and pipeline flush.

---
 rtl/ysyx_25030077_idu_pkg.sv | 40 ++++
 rtl/ysyx_25030077_idu_dec.sv | 51 +++++
 rtl/ysyx_25030077_idu_seq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ysyx_25030077_idu_pkg.sv
// Shared decode constants, immediate-select encoding and sequencer state type
// for the ysyx_25030077 decode-stage sequencer.
package ysyx_25030077_idu_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] IMM_NONE  = 3'd0;
  localparam logic [2:0] IMM_I     = 3'd1;
  localparam logic [2:0] IMM_U     = 3'd2;
  localparam logic [2:0] IMM_C4    = 3'd3;
  localparam logic [2:0] IMM_S     = 3'd4;
  localparam logic [2:0] IMM_SHAMT = 3'd5;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  typedef struct packed {
    logic [1:0] nuops;
    logic [2:0] imm_type0;
    logic [2:0] imm_type1;
    logic       illegal;
  } dec_t;

  // Shift-immediate forms take the 5-bit shamt instead of a sign-extended imm.
  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/ysyx_25030077_idu_dec.sv
// Combinational opcode classifier: uop count, per-uop immediate select and
// illegal-instruction flag for one 32-bit instruction word.
module ysyx_25030077_idu_dec
  import ysyx_25030077_idu_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic [1:0]  nuops_o,
  output logic [2:0]  imm_type0_o,
  output logic [2:0]  imm_type1_o,
  output logic        illegal_o
);

  logic [6:0] opc_s;
  logic [2:0] f3_s;
  logic       unused_s;

  assign opc_s    = inst_i[6:0];
  assign f3_s     = inst_i[14:12];
  assign unused_s = ^{inst_i[31:15], inst_i[11:7]};

  // Opcode table lookup; anything unrecognised becomes a single illegal uop.
  always_comb begin
    nuops_o     = 2'd1;
    imm_type0_o = IMM_NONE;
    imm_type1_o = IMM_NONE;
    illegal_o   = 1'b0;
    if (inst_i[1:0] != 2'b11) begin
      illegal_o = 1'b1;
    end else begin
      case (opc_s)
        OPC_LUI, OPC_AUIPC: imm_type0_o = IMM_U;
        OPC_JAL: begin
          nuops_o     = 2'd2;
          imm_type0_o = IMM_C4;
          imm_type1_o = IMM_NONE;
        end
        OPC_JALR: begin
          nuops_o     = 2'd2;
          imm_type0_o = IMM_C4;
          imm_type1_o = IMM_I;
        end
        OPC_LOAD:  imm_type0_o = IMM_I;
        OPC_STORE: imm_type0_o = IMM_S;
        OPC_OPIMM: imm_type0_o = is_shift_f3(f3_s) ? IMM_SHAMT : IMM_I;
        OPC_BRANCH, OPC_OP, OPC_SYSTEM: imm_type0_o = IMM_NONE;
        default: illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_25030077_idu_seq.sv
// Decode-stage sequencer: latches one instruction per handshake and issues its
// one or two uops to the EXU. Optional counters: YSYX_25030077_IDU_PERF_EN.
module ysyx_25030077_idu_seq
  import ysyx_25030077_idu_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [31:0]       io_in_inst,
  input  logic [31:0]       io_in_pc,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [31:0]       io_out_inst,
  output logic [31:0]       io_out_pc,
  output logic [2:0]        io_out_imm_type,
  output logic              io_out_uop,
  output logic              io_out_last,
  output logic              io_out_illegal,
  input  logic              io_flush
`ifdef YSYX_25030077_IDU_PERF_EN
  ,
  output logic [PERF_W-1:0] io_perf_issue,
  output logic [PERF_W-1:0] io_perf_stall
`endif
);

  state_e      state_q;
  logic        valid_q;
  logic [31:0] inst_q;
  logic [31:0] pc_q;
  logic [2:0]  imm_q;
  logic [2:0]  imm1_q;
  logic        uop_q;
  logic        last_q;
  logic        illegal_q;

  dec_t        dec_s;
  logic        in_fire_s;
  logic        out_fire_s;

  ysyx_25030077_idu_dec u_dec (
    .inst_i      (io_in_inst),
    .nuops_o     (dec_s.nuops),
    .imm_type0_o (dec_s.imm_type0),
    .imm_type1_o (dec_s.imm_type1),
    .illegal_o   (dec_s.illegal)
  );

  // Ready looks through the final uop's handshake so a new instruction can
  // follow with no bubble.
  assign io_in_ready = (state_q == ST_IDLE) ||
                       ((state_q == ST_ISSUE) && out_fire_s && last_q);
  assign in_fire_s   = io_in_valid && io_in_ready;
  assign out_fire_s  = valid_q && io_out_ready;

  // Sequencer FSM with its registered uop payload; flush beats both handshakes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      inst_q    <= 32'd0;
      pc_q      <= 32'd0;
      imm_q     <= IMM_NONE;
      imm1_q    <= IMM_NONE;
      uop_q     <= 1'b0;
      last_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (io_flush) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      uop_q   <= 1'b0;
    end else if (in_fire_s) begin
      state_q   <= ST_ISSUE;
      valid_q   <= 1'b1;
      inst_q    <= io_in_inst;
      pc_q      <= io_in_pc;
      imm_q     <= dec_s.imm_type0;
      imm1_q    <= dec_s.imm_type1;
      uop_q     <= 1'b0;
      last_q    <= (dec_s.nuops == 2'd1);
      illegal_q <= dec_s.illegal;
    end else if (out_fire_s) begin
      if (last_q) begin
        state_q <= ST_IDLE;
        valid_q <= 1'b0;
      end else begin
        uop_q  <= 1'b1;
        imm_q  <= imm1_q;
        last_q <= 1'b1;
      end
    end else begin
      state_q <= state_q;
    end
  end

  assign io_out_valid    = valid_q;
  assign io_out_inst     = inst_q;
  assign io_out_pc       = pc_q;
  assign io_out_imm_type = imm_q;
  assign io_out_uop      = uop_q;
  assign io_out_last     = last_q;
  assign io_out_illegal  = illegal_q;

`ifdef YSYX_25030077_IDU_PERF_EN
  logic [PERF_W-1:0] issue_q;
  logic [PERF_W-1:0] stall_q;

  // Free-running wrap-around counters; only reset clears them, not flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      issue_q <= '0;
      stall_q <= '0;
    end else begin
      if (out_fire_s) begin
        issue_q <= issue_q + 1'b1;
      end
      if (valid_q && !io_out_ready) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign io_perf_issue = issue_q;
  assign io_perf_stall = stall_q;
`else
  localparam int unused_perf_w = PERF_W;
`endif

endmodule
